// File: rtl/superh16_late_wb_buffer.sv
// Late writeback buffer: in-order circular queue of variable-latency results,
// drained onto register file write lanes the fixed-latency pipes leave idle.
module superh16_late_wb_buffer #(
  parameter int unsigned N_IN          = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ISSUE_WIDTH   = 12,
  parameter int unsigned PHYS_REG_BITS = 10,
  parameter int unsigned XLEN          = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [PHYS_REG_BITS-1:0] in_tag [N_IN],
  input  logic [XLEN-1:0]          in_data [N_IN],
  output logic                     in_ready,
  input  logic                     flush,
  input  logic [ISSUE_WIDTH-1:0]   lane_busy_nxt,
  output logic [ISSUE_WIDTH-1:0]   wb_valid,
  output logic [PHYS_REG_BITS-1:0] wb_tag [ISSUE_WIDTH],
  output logic [XLEN-1:0]          wb_data [ISSUE_WIDTH],
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PHYS_REG_BITS-1:0] mem_tag  [DEPTH];
  logic [XLEN-1:0]          mem_data [DEPTH];
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            count;

  logic [N_IN-1:0]          wr_en;
  logic [PW-1:0]            wr_idx [N_IN];
  logic [CW-1:0]            enq_cnt;
  logic [ISSUE_WIDTH-1:0]   rd_en;
  logic [PW-1:0]            rd_idx [ISSUE_WIDTH];
  logic [CW-1:0]            pop_cnt;

  // Ready depends only on the registered count so a same-cycle pop never raises it.
  assign in_ready  = rst_n && !flush && ((CW'(DEPTH) - count) >= CW'(N_IN));
  assign occupancy = count;

  // Compact accepted non-zero-tag channels onto consecutive tail slots.
  always_comb begin
    enq_cnt = '0;
    wr_en   = '0;
    for (int i = 0; i < N_IN; i++) begin
      wr_idx[i] = tail + enq_cnt[PW-1:0];
      if (in_ready && in_valid[i] && (in_tag[i] != '0)) begin
        wr_en[i] = 1'b1;
        enq_cnt  = enq_cnt + CW'(1);
      end
    end
  end

  // Oldest entries go to the lowest-indexed free lanes.
  always_comb begin
    pop_cnt = '0;
    rd_en   = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      rd_idx[k] = head + pop_cnt[PW-1:0];
      if (!lane_busy_nxt[k] && (pop_cnt < count)) begin
        rd_en[k] = 1'b1;
        pop_cnt  = pop_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (wr_en[i]) begin
        mem_tag[wr_idx[i]]  <= in_tag[i];
        mem_data[wr_idx[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wb_valid <= '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        wb_tag[k]  <= '0;
        wb_data[k] <= '0;
      end
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wb_valid <= '0;
    end else begin
      head     <= head + pop_cnt[PW-1:0];
      tail     <= tail + enq_cnt[PW-1:0];
      count    <= count + enq_cnt - pop_cnt;
      wb_valid <= rd_en;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (rd_en[k]) begin
          wb_tag[k]  <= mem_tag[rd_idx[k]];
          wb_data[k] <= mem_data[rd_idx[k]];
        end
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane_chk
    a_no_collide: assert property (@(posedge clk) disable iff (!rst_n)
      wb_valid[k] |-> !$past(lane_busy_nxt[k]));
    for (genvar j = k + 1; j < ISSUE_WIDTH; j++) begin : g_pair_chk
      a_uniq_tag: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid[k] && wb_valid[j]) |-> (wb_tag[k] != wb_tag[j]));
    end
  end

endmodule
